half_adder: RTL and testbench

- Bit-wise half adder, the basic arithmetic cell used by the 4-bit counter datapath.
- Produces sum (XOR) and carry (AND) of two operand vectors.
- Combinational outputs are valid in the same cycle, so the block can be tested without clocking.
- A registered copy of the result, with synchronous active-low reset, feeds clocked consumers.

---
 rtl/half_adder_pkg.sv | 7 +
 rtl/half_adder_cell.sv | 13 +
 rtl/half_adder.sv | 42 ++++
 tb/tb_half_adder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Project-wide constants shared by the half-adder slice.
package half_adder_pkg;

  // Level of rst_ni that clears the registered outputs.
  localparam logic RST_LEVEL = 1'b0;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// One-bit half-adder cell: sum is XOR, carry is AND of the two operand bits.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Pure combinational lane; the two outputs can never both be 1.
  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with combinational outputs and a
// one-cycle registered copy cleared by a synchronous active-low reset.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] c_o,
  output logic [WIDTH-1:0] s_q_o,
  output logic [WIDTH-1:0] c_q_o
);

  // One cell per lane; lanes share nothing, so no carry ripples between them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (a_i[i]),
      .b (b_i[i]),
      .s (s_o[i]),
      .c (c_o[i])
    );
  end

  // Output register: cleared on a reset edge, otherwise captures this cycle's result.
  // NOTE: reset is sampled only on the clock edge, so it is left out of the
  // sensitivity list; non-blocking assignments keep both registers sampling
  // the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_ni == RST_LEVEL) begin
      s_q_o <= '0;
      c_q_o <= '0;
    end else begin
      s_q_o <= s_o;
      c_q_o <= c_o;
    end
  end

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder at WIDTH=1 and WIDTH=4.
module tb_half_adder;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, s1, c1, sq1, cq1;
  logic [3:0] a4, b4, s4, c4, sq4, cq4;

  int checks = 0;
  int errors = 0;

  half_adder #(.WIDTH(1)) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .a_i    (a1),
    .b_i    (b1),
    .s_o    (s1),
    .c_o    (c1),
    .s_q_o  (sq1),
    .c_q_o  (cq1)
  );

  half_adder #(.WIDTH(4)) u_dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .a_i    (a4),
    .b_i    (b4),
    .s_o    (s4),
    .c_o    (c4),
    .s_q_o  (sq4),
    .c_q_o  (cq4)
  );

  // Rising edges at 5, 15, 25, ... ns.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] sum2;
    logic [3:0] es, ec;

    // Combinational truth table, WIDTH=1, reset held asserted throughout.
    rst_n = 1'b0; a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    #1;  check("w1 a0b0 c", 8'(c1), 8'h0); check("w1 a0b0 s", 8'(s1), 8'h0);
    #49; a1 = 1'b0; b1 = 1'b1;
    #1;  check("w1 a0b1 c", 8'(c1), 8'h0); check("w1 a0b1 s", 8'(s1), 8'h1);
    #49; a1 = 1'b1; b1 = 1'b0;
    #1;  check("w1 a1b0 c", 8'(c1), 8'h0); check("w1 a1b0 s", 8'(s1), 8'h1);
    #49; a1 = 1'b1; b1 = 1'b1;
    #1;  check("w1 a1b1 c", 8'(c1), 8'h1); check("w1 a1b1 s", 8'(s1), 8'h0);

    // Registered path: two reset edges with a=b=1 keep the registers cleared.
    tick(); tick();
    check("rst sq", 8'(sq1), 8'h0); check("rst cq", 8'(cq1), 8'h0);

    // Release reset: first edge loads the current result.
    rst_n = 1'b1;
    tick();
    check("rel sq", 8'(sq1), 8'h0); check("rel cq", 8'(cq1), 8'h1);

    // New inputs appear on the registers only after the next edge.
    a1 = 1'b0; b1 = 1'b1;
    #1;  check("hold sq", 8'(sq1), 8'h0); check("hold cq", 8'(cq1), 8'h1);
    tick();
    check("lat sq", 8'(sq1), 8'h1); check("lat cq", 8'(cq1), 8'h0);

    // Mid-stream reset: combinational keeps following, registers clear at the edge.
    rst_n = 1'b0; a1 = 1'b1; b1 = 1'b1;
    #1;  check("mid c", 8'(c1), 8'h1); check("mid s", 8'(s1), 8'h0);
    check("mid pre sq", 8'(sq1), 8'h1); check("mid pre cq", 8'(cq1), 8'h0);
    tick();
    check("mid sq", 8'(sq1), 8'h0); check("mid cq", 8'(cq1), 8'h0);
    rst_n = 1'b1; a1 = 1'b1; b1 = 1'b0;
    tick();
    check("rerel sq", 8'(sq1), 8'h1); check("rerel cq", 8'(cq1), 8'h0);

    // WIDTH=4 directed vector.
    a4 = 4'b1100; b4 = 4'b1010;
    #1;  check("w4 s", 8'(s4), 8'h06); check("w4 c", 8'(c4), 8'h08);
    tick();
    check("w4 sq", 8'(sq4), 8'h06); check("w4 cq", 8'(cq4), 8'h08);

    // Exhaustive WIDTH=1: {c,s} equals a+b, never both set.
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      sum2 = {1'b0, a1} + {1'b0, b1};
      #1;
      check("sw1 cs", 8'({c1, s1}), 8'(sum2));
      check("sw1 inv", 8'(c1 & s1), 8'h0);
      tick();
      check("sw1 q", 8'({cq1, sq1}), 8'(sum2));
    end

    // Exhaustive WIDTH=4: each lane adds independently.
    for (int i = 0; i < 256; i++) begin
      a4 = i[7:4]; b4 = i[3:0];
      for (int k = 0; k < 4; k++) begin
        sum2  = {1'b0, a4[k]} + {1'b0, b4[k]};
        es[k] = sum2[0];
        ec[k] = sum2[1];
      end
      #1;
      check("sw4 s", 8'(s4), 8'(es));
      check("sw4 c", 8'(c4), 8'(ec));
      check("sw4 inv", 8'(c4 & s4), 8'h0);
      tick();
      check("sw4 sq", 8'(sq4), 8'(es));
      check("sw4 cq", 8'(cq4), 8'(ec));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_half_adder
